// File: rtl/tcls_resync_pkg.sv
// Shared types and defaults for the lock-step resync controller.
package tcls_resync_pkg;

  // 3-bit FSM encoding, exported unchanged on state_o.
  typedef enum logic [2:0] {
    ST_RUN    = 3'd0,
    ST_DRAIN  = 3'd1,
    ST_UNLOAD = 3'd2,
    ST_RESET  = 3'd3,
    ST_RELOAD = 3'd4,
    ST_FAIL   = 3'd5
  } state_t;

  localparam int unsigned DefaultCntWidth       = 8;
  localparam int unsigned DefaultMaxOutstanding = 2;
  localparam int unsigned DefaultResetCycles    = 8;
  localparam int unsigned DefaultTimeoutCycles  = 1024;

  // Wider of the two dwell limits; sizes the shared per-state timer.
  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/tcls_outstanding_cnt.sv
// Saturating in-flight transaction counter for one bus; reports idle.
module tcls_outstanding_cnt
  import tcls_resync_pkg::*;
#(
  parameter int unsigned MaxOutstanding = DefaultMaxOutstanding
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic req_i,
  input  logic gnt_i,
  input  logic rvalid_i,
  output logic idle_o
);

  localparam int unsigned CntW = $clog2(MaxOutstanding + 1);

  logic [CntW-1:0] count_reg, count_next;
  logic            issue;

  // Grant adds one, response removes one; both together cancel out.
  always_comb begin
    issue      = req_i & gnt_i;
    count_next = count_reg;
    if (issue && !rvalid_i) begin
      if (count_reg < CntW'(MaxOutstanding)) begin
        count_next = count_reg + 1'b1;
      end
    end else if (rvalid_i && !issue && (count_reg != '0)) begin
      count_next = count_reg - 1'b1;
    end
  end

  // Count register; clear wins over traffic.
  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_next;
    end
  end

  assign idle_o = (count_reg == '0);

endmodule

// File: rtl/tcls_resync_ctrl.sv
// Recovery sequencer for the triple-core lock-step wrapper.
module tcls_resync_ctrl
  import tcls_resync_pkg::*;
#(
  parameter int unsigned CntWidth       = DefaultCntWidth,
  parameter int unsigned MaxOutstanding = DefaultMaxOutstanding,
  parameter int unsigned ResetCycles    = DefaultResetCycles,
  parameter int unsigned TimeoutCycles  = DefaultTimeoutCycles
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  enable_i,
  input  logic [2:0]            error_cba_i,
  input  logic                  instr_req_i,
  input  logic                  instr_gnt_i,
  input  logic                  instr_rvalid_i,
  input  logic                  data_req_i,
  input  logic                  data_gnt_i,
  input  logic                  data_rvalid_i,
  input  logic                  resync_irq_ack_i,
  input  logic                  unload_done_i,
  input  logic                  reload_done_i,
  output logic                  bus_block_o,
  output logic                  resync_irq_o,
  output logic [2:0]            core_rst_o,
  output logic                  boot_sel_o,
  output logic [2:0]            state_o,
  output logic [2:0]            faulty_core_o,
  output logic [3*CntWidth-1:0] mismatch_cnt_o,
  output logic                  fail_o,
  output logic                  timeout_o
);

  localparam int unsigned TimerW = $clog2(max_u(TimeoutCycles, ResetCycles) + 1);

  state_t            state_reg, state_next;
  logic [TimerW-1:0] timer_reg;
  logic [2:0]        faulty_reg, faulty_next;
  logic              timeout_reg, timeout_next;
  logic              ack_seen_reg;
  logic              count_mismatch;
  logic              instr_idle, data_idle;
  logic              timer_expired, reset_done;

  // In-flight trackers, zeroed while the cores are held in reset.
  tcls_outstanding_cnt #(.MaxOutstanding(MaxOutstanding)) u_instr_cnt (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .clr_i    (state_reg == ST_RESET),
    .req_i    (instr_req_i),
    .gnt_i    (instr_gnt_i),
    .rvalid_i (instr_rvalid_i),
    .idle_o   (instr_idle)
  );

  tcls_outstanding_cnt #(.MaxOutstanding(MaxOutstanding)) u_data_cnt (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .clr_i    (state_reg == ST_RESET),
    .req_i    (data_req_i),
    .gnt_i    (data_gnt_i),
    .rvalid_i (data_rvalid_i),
    .idle_o   (data_idle)
  );

  assign timer_expired = (timer_reg == TimerW'(TimeoutCycles - 1));
  assign reset_done    = (timer_reg == TimerW'(ResetCycles - 1));

  // Next-state logic; a regular exit takes priority over a timeout in the same cycle.
  always_comb begin
    state_next     = state_reg;
    faulty_next    = faulty_reg;
    timeout_next   = timeout_reg;
    count_mismatch = 1'b0;
    unique case (state_reg)
      ST_RUN: begin
        if (enable_i && (error_cba_i != 3'b000)) begin
          count_mismatch = 1'b1;
          faulty_next    = error_cba_i;
          state_next     = ((error_cba_i & (error_cba_i - 3'd1)) == 3'b000) ? ST_DRAIN : ST_FAIL;
        end
      end
      ST_DRAIN: begin
        if (instr_idle && data_idle) begin
          state_next = ST_UNLOAD;
        end else if (timer_expired) begin
          state_next   = ST_FAIL;
          timeout_next = 1'b1;
        end
      end
      ST_UNLOAD: begin
        if (ack_seen_reg && unload_done_i) begin
          state_next = ST_RESET;
        end else if (timer_expired) begin
          state_next   = ST_FAIL;
          timeout_next = 1'b1;
        end
      end
      ST_RESET: begin
        if (reset_done) begin
          state_next = ST_RELOAD;
        end
      end
      ST_RELOAD: begin
        if (reload_done_i) begin
          state_next  = ST_RUN;
          faulty_next = 3'b000;
        end else if (timer_expired) begin
          state_next   = ST_FAIL;
          timeout_next = 1'b1;
        end
      end
      ST_FAIL: begin
        state_next = ST_FAIL;
      end
      default: begin
        state_next = ST_FAIL;
      end
    endcase
  end

  // State, latched faulty core and sticky timeout flag.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg   <= ST_RUN;
      faulty_reg  <= 3'b000;
      timeout_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      faulty_reg  <= faulty_next;
      timeout_reg <= timeout_next;
    end
  end

  // Dwell timer: restarts on every state change, runs in the sequencing states.
  always_ff @(posedge clk_i) begin
    if (rst_i || (state_next != state_reg)) begin
      timer_reg <= '0;
    end else if ((state_reg != ST_RUN) && (state_reg != ST_FAIL)) begin
      timer_reg <= timer_reg + 1'b1;
    end
  end

  // Remembers the interrupt ack for the current UNLOAD visit only.
  always_ff @(posedge clk_i) begin
    if (rst_i || (state_reg != ST_UNLOAD)) begin
      ack_seen_reg <= 1'b0;
    end else if (resync_irq_ack_i) begin
      ack_seen_reg <= 1'b1;
    end
  end

  // Per-core saturating mismatch counters.
  for (genvar gi = 0; gi < 3; gi++) begin : g_mcnt
    logic [CntWidth-1:0] cnt_reg;
    // Bump on a qualified mismatch in RUN, stick at all-ones.
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        cnt_reg <= '0;
      end else if (count_mismatch && error_cba_i[gi] && (cnt_reg != '1)) begin
        cnt_reg <= cnt_reg + 1'b1;
      end
    end
    assign mismatch_cnt_o[gi*CntWidth +: CntWidth] = cnt_reg;
  end

  assign state_o       = state_reg;
  assign bus_block_o   = (state_reg == ST_DRAIN) || (state_reg == ST_RESET) || (state_reg == ST_FAIL);
  assign resync_irq_o  = (state_reg == ST_UNLOAD) && !ack_seen_reg;
  assign core_rst_o    = (state_reg == ST_RESET) ? 3'b111 : 3'b000;
  assign boot_sel_o    = (state_reg == ST_RESET) || (state_reg == ST_RELOAD);
  assign faulty_core_o = faulty_reg;
  assign fail_o        = (state_reg == ST_FAIL);
  assign timeout_o     = timeout_reg;

endmodule

// File: tb/tb_tcls_resync_ctrl.sv
// Self-checking bench: directed table, corner sequences and a random run vs. a reference model.
module tb_tcls_resync_ctrl;

  localparam int CW  = 8;
  localparam int MO  = 2;
  localparam int RC  = 8;
  localparam int TO  = 1024;
  localparam int SAT = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst, en;
  logic [2:0] err;
  logic ireq, ignt, irv, dreq, dgnt, drv, ack, ud, rd;
  logic bus_block, irq, boot_sel, fail, tmo;
  logic [2:0] core_rst, state, faulty;
  logic [3*CW-1:0] mcnt;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: phase number, cycles spent in it, bus occupancy, counters.
  int m_state, m_dwell, m_io, m_do;
  bit m_ack, m_timeout;
  logic [2:0] m_faulty;
  int m_cnt[3];

  always #5 clk = ~clk;

  tcls_resync_ctrl #(.CntWidth(CW), .MaxOutstanding(MO), .ResetCycles(RC), .TimeoutCycles(TO)) dut (
    .clk_i(clk), .rst_i(rst), .enable_i(en), .error_cba_i(err),
    .instr_req_i(ireq), .instr_gnt_i(ignt), .instr_rvalid_i(irv),
    .data_req_i(dreq), .data_gnt_i(dgnt), .data_rvalid_i(drv),
    .resync_irq_ack_i(ack), .unload_done_i(ud), .reload_done_i(rd),
    .bus_block_o(bus_block), .resync_irq_o(irq), .core_rst_o(core_rst),
    .boot_sel_o(boot_sel), .state_o(state), .faulty_core_o(faulty),
    .mismatch_cnt_o(mcnt), .fail_o(fail), .timeout_o(tmo)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic int occ(input int o, input logic issue, input logic ret);
    if (issue && !ret) return (o + 1 > MO) ? MO : o + 1;
    if (ret && !issue) return (o - 1 < 0) ? 0 : o - 1;
    return o;
  endfunction

  // Advance the model by one clock using the inputs currently driven.
  task automatic model_next();
    int  ns;
    bit  to;
    if (rst) begin
      m_state = 0; m_dwell = 0; m_io = 0; m_do = 0; m_ack = 0;
      m_timeout = 0; m_faulty = 3'b000; m_cnt = '{0, 0, 0};
      return;
    end
    ns = m_state;
    to = 0;
    case (m_state)
      0: if (en && err != 3'b000) begin
           m_faulty = err;
           for (int i = 0; i < 3; i++)
             if (err[i]) m_cnt[i] = (m_cnt[i] >= SAT) ? SAT : m_cnt[i] + 1;
           ns = ($countones(err) == 1) ? 1 : 5;
         end
      1: if (m_io == 0 && m_do == 0) ns = 2; else to = (m_dwell + 1 >= TO);
      2: if (m_ack && ud) ns = 3; else to = (m_dwell + 1 >= TO);
      3: if (m_dwell + 1 >= RC) ns = 4;
      4: if (rd) begin ns = 0; m_faulty = 3'b000; end else to = (m_dwell + 1 >= TO);
      default: ;
    endcase
    if (to) begin ns = 5; m_timeout = 1; end
    if (m_state == 3) begin
      m_io = 0; m_do = 0;
    end else begin
      m_io = occ(m_io, ireq & ignt, irv);
      m_do = occ(m_do, dreq & dgnt, drv);
    end
    m_ack = (m_state == 2 && ns == 2) ? (m_ack | ack) : 1'b0;
    m_dwell = (ns != m_state) ? 0 : m_dwell + 1;
    m_state = ns;
  endtask

  function automatic logic [37:0] model_vec();
    logic [2:0] s;
    s = 3'(m_state);
    return {s, (m_state == 1 || m_state == 3 || m_state == 5), (m_state == 2 && !m_ack),
            (m_state == 3) ? 3'b111 : 3'b000, (m_state == 3 || m_state == 4), m_faulty,
            CW'(m_cnt[2]), CW'(m_cnt[1]), CW'(m_cnt[0]), (m_state == 5), m_timeout};
  endfunction

  // One clock: update the model, let the edge pass, compare every output.
  task automatic step();
    model_next();
    @(posedge clk);
    #1;
    check("model", {26'd0, state, bus_block, irq, core_rst, boot_sel, faulty, mcnt, fail, tmo},
          {26'd0, model_vec()});
  endtask

  task automatic idle_inputs();
    rst = 0; en = 1; err = 3'b000; ack = 0; ud = 0; rd = 0;
    ireq = 0; ignt = 0; irv = 0; dreq = 0; dgnt = 0; drv = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1;
    step();
    rst = 0;
  endtask

  // Full recovery from RUN with idle buses; injects a mismatch pulse during RELOAD.
  task automatic run_recovery(input logic [2:0] e, input logic [2:0] reload_noise);
    err = e; step(); err = 3'b000;
    step();
    ack = 1; step(); ack = 0;
    ud = 1; step(); ud = 0;
    for (int i = 0; i < RC; i++) step();
    err = reload_noise; step(); err = 3'b000;
    rd = 1; step(); rd = 0;
  endtask

  typedef struct {
    logic [2:0] err;
    logic       ack, ud, rd;
    logic [2:0] exp_state;
    logic       exp_irq;
    logic [2:0] exp_crst;
    logic [2:0] exp_faulty;
  } vec_t;

  vec_t vecs[13];

  function automatic vec_t mk(input logic [2:0] e, input logic a, input logic u, input logic r,
                              input logic [2:0] s, input logic i, input logic [2:0] c,
                              input logic [2:0] f);
    vec_t v;
    v.err = e; v.ack = a; v.ud = u; v.rd = r;
    v.exp_state = s; v.exp_irq = i; v.exp_crst = c; v.exp_faulty = f;
    return v;
  endfunction

  initial begin
    // Core 1 mismatch walked through the whole sequence, one row per cycle.
    vecs[0] = mk(3'b010, 0, 0, 0, 3'd1, 0, 3'b000, 3'b010);
    vecs[1] = mk(3'b000, 0, 0, 0, 3'd2, 1, 3'b000, 3'b010);
    vecs[2] = mk(3'b000, 1, 0, 0, 3'd2, 0, 3'b000, 3'b010);
    vecs[3] = mk(3'b000, 0, 1, 0, 3'd3, 0, 3'b111, 3'b010);
    for (int i = 4; i <= 10; i++) vecs[i] = mk(3'b000, 0, 0, 0, 3'd3, 0, 3'b111, 3'b010);
    vecs[11] = mk(3'b000, 0, 0, 0, 3'd4, 0, 3'b000, 3'b010);
    vecs[12] = mk(3'b000, 0, 0, 1, 3'd0, 0, 3'b000, 3'b000);

    do_reset();
    check("reset_state", {57'd0, state, bus_block, irq, fail, tmo}, 64'd0);
    check("reset_cnt", {40'd0, mcnt}, 64'd0);

    // Unload pulse before the ack must be dropped: tested inside the table via row order,
    // plus a dedicated early pulse below.
    for (int i = 0; i < 13; i++) begin
      err = vecs[i].err; ack = vecs[i].ack; ud = vecs[i].ud; rd = vecs[i].rd;
      step();
      check($sformatf("vec%0d", i), {52'd0, state, irq, core_rst, faulty},
            {52'd0, vecs[i].exp_state, vecs[i].exp_irq, vecs[i].exp_crst, vecs[i].exp_faulty});
    end
    idle_inputs();
    check("core1_cnt", {40'd0, mcnt}, {40'd0, 8'd0, 8'd1, 8'd0});

    // Early unload_done ignored, then a data drain with two outstanding transactions.
    do_reset();
    dreq = 1; dgnt = 1; step(); step(); dreq = 0; dgnt = 0;
    err = 3'b100; step(); err = 3'b000;
    check("drain_enter", {60'd0, state, bus_block}, {60'd0, 3'd1, 1'b1});
    step(); step();
    check("drain_hold", {60'd0, state, bus_block}, {60'd0, 3'd1, 1'b1});
    drv = 1; step(); step(); drv = 0;
    check("drain_after_2nd_rv", {61'd0, state}, {61'd0, 3'd1});
    step();
    check("drain_exit", {61'd0, state}, {61'd0, 3'd2});
    ud = 1; step(); ud = 0;
    check("early_unload_dropped", {61'd0, state}, {61'd0, 3'd2});
    ack = 1; step(); ack = 0;
    ud = 1; step(); ud = 0;
    check("unload_accepted", {61'd0, state}, {61'd0, 3'd3});

    // Two cores disagree: absorbing FAIL.
    do_reset();
    err = 3'b011; step(); err = 3'b000;
    check("fail_dual", {40'd0, mcnt}, {40'd0, 8'd0, 8'd1, 8'd1});
    check("fail_flags", {60'd0, state, fail}, {60'd0, 3'd5, 1'b1});
    for (int i = 0; i < 20; i++) begin
      ack = 1'($urandom); ud = 1'($urandom); rd = 1'($urandom); err = 3'($urandom);
      step();
    end
    idle_inputs();
    check("fail_sticky", {59'd0, state, fail, bus_block}, {59'd0, 3'd5, 1'b1, 1'b1});

    // UNLOAD timeout.
    do_reset();
    err = 3'b001; step(); err = 3'b000;
    step();
    for (int i = 0; i < TO - 1; i++) step();
    check("unload_pre_timeout", {60'd0, state, tmo}, {60'd0, 3'd2, 1'b0});
    step();
    check("unload_timeout", {59'd0, state, fail, tmo}, {59'd0, 3'd5, 1'b1, 1'b1});
    do_reset();
    check("timeout_cleared", {34'd0, state, fail, tmo, faulty, mcnt}, 64'd0);

    // Saturation of the core 0 counter; RELOAD noise does not count.
    do_reset();
    for (int k = 0; k < 256; k++) run_recovery(3'b001, 3'b001);
    check("sat_cnt0", {40'd0, mcnt}, {40'd0, 8'd0, 8'd0, 8'(SAT)});

    // Reset in the middle of RESET.
    do_reset();
    err = 3'b010; step(); err = 3'b000;
    step(); ack = 1; step(); ack = 0; ud = 1; step(); ud = 0;
    step(); step();
    check("in_reset_c3", {61'd0, core_rst}, {61'd0, 3'b111});
    rst = 1; step(); rst = 0;
    check("rst_mid_reset", {34'd0, state, core_rst, faulty, mcnt}, 64'd0);

    // Random traffic and faults against the model.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      rst  = ($urandom_range(0, 299) == 0);
      en   = ($urandom_range(0, 9) != 0);
      err  = ($urandom_range(0, 19) == 0) ? 3'($urandom_range(1, 7)) : 3'b000;
      ireq = 1'($urandom); ignt = 1'($urandom); irv = 1'($urandom);
      dreq = 1'($urandom); dgnt = 1'($urandom); drv = 1'($urandom);
      ack  = ($urandom_range(0, 3) == 0);
      ud   = ($urandom_range(0, 3) == 0);
      rd   = ($urandom_range(0, 7) == 0);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/tcls_resync_ctrl.md
Name: tcls_resync_ctrl

Overview:
- Recovery sequencer for the triple-core lock-step wrapper.
- Consumes the per-core mismatch flags from the TMR voters and the voted instruction/data bus handshakes.
- On a single-core mismatch it blocks the bus and drains outstanding transactions. It then requests a state unload via interrupt, resets all three cores in lock-step and waits for reload before resuming TMR execution.
- Keeps saturating per-core mismatch counters and a sticky fail/timeout status for the register file.

Parameters:
- CntWidth, 8, width of each per-core mismatch counter.
- MaxOutstanding, 2, maximum in-flight transactions per bus (instr and data tracked separately).
- ResetCycles, 8, cycles core_rst_o is held asserted (legal range >= 1).
- TimeoutCycles, 1024, cycle budget allowed in each of DRAIN, UNLOAD and RELOAD.

Ports:
- clk_i  in  1  clock; the only clock.
- rst_i  in  1  synchronous, active-high reset.
- enable_i  in  1  TMR checking enabled (cores fetching).
- error_cba_i  in  3  per-core mismatch flags from the voters, already qualified by data_req.
- instr_req_i, instr_gnt_i, instr_rvalid_i  in  1 each  voted instruction-bus handshake.
- data_req_i, data_gnt_i, data_rvalid_i  in  1 each  voted data-bus handshake.
- resync_irq_ack_i  in  1  voted core acknowledge of the resync interrupt.
- unload_done_i  in  1  single-cycle pulse: software finished storing state.
- reload_done_i  in  1  single-cycle pulse: software finished restoring state.
- bus_block_o  out  1  gate new requests toward the interconnect.
- resync_irq_o  out  1  force the resync interrupt to all cores.
- core_rst_o  out  3  lock-step core reset, active-high; the wrapper inverts it.
- boot_sel_o  out  1  select the restore boot address.
- state_o  out  3  current FSM state encoding.
- faulty_core_o  out  3  one-hot latched faulty core.
- mismatch_cnt_o  out  3*CntWidth  per-core mismatch counters; core i at [i*CntWidth +: CntWidth].
- fail_o  out  1  sticky unrecoverable error.
- timeout_o  out  1  sticky; set when fail_o was caused by a timeout.

Behaviour:
- Reset values: all outputs 0, state RUN, all counters 0.
- Every output is a registered state decode or register; no combinational path from any input to any output.
- Outstanding counters (instr and data, independent):
  - +1 on req&gnt; -1 on rvalid; both in the same cycle leaves the count unchanged.
  - Saturate at MaxOutstanding; an rvalid at 0 is ignored.
  - Counters run in every state except RESET, where they are forced to 0.
- RUN (all outputs low):
  - If enable_i=1 and error_cba_i!=0:
    - latch faulty_core_o=error_cba_i;
    - increment mismatch_cnt[i] for every set bit, saturating at all-ones;
    - exactly one bit set: go to DRAIN;
    - two or more bits set: go to FAIL.
  - If enable_i=0, error_cba_i is ignored.
- DRAIN:
  - bus_block_o=1.
  - When both outstanding counts are 0 (evaluated at the start of the cycle), go to UNLOAD.
- UNLOAD:
  - bus_block_o=0, so cores can store state.
  - resync_irq_o=1 until the first cycle resync_irq_ack_i=1; it deasserts the following cycle.
  - unload_done_i is accepted only after the ack has been seen; when accepted, go to RESET.
  - An unload_done_i pulse before the ack is dropped.
- RESET:
  - core_rst_o=3'b111, boot_sel_o=1, bus_block_o=1.
  - Hold for exactly ResetCycles cycles, then go to RELOAD.
- RELOAD:
  - boot_sel_o=1, bus_block_o=0.
  - On reload_done_i, go to RUN and clear faulty_core_o.
- FAIL:
  - bus_block_o=1, fail_o=1.
  - Absorbing; only rst_i leaves it.
- Timeout:
  - A single timer resets on every state entry and counts in DRAIN, UNLOAD and RELOAD.
  - Reaching TimeoutCycles goes to FAIL and sets timeout_o=1.
- error_cba_i is ignored in every state except RUN; counters do not change.
- rst_i asserted mid-sequence:
  - returns to RUN next edge and clears all counters, faulty_core_o, fail_o and timeout_o;
  - core_rst_o deasserts immediately on that edge.
- State encoding: RUN=0, DRAIN=1, UNLOAD=2, RESET=3, RELOAD=4, FAIL=5.

Decomposition:
- Package tcls_resync_pkg: state enum (3-bit), state encodings, default timeout and reset constants.
- One natural sub-module, tcls_outstanding_cnt: saturating up/down in-flight counter with a clear input, instantiated once per bus.
- Mismatch counters, timer and FSM stay in the top module.

Test Plan:
- Core 1 mismatch (error_cba_i=3'b010, one cycle) with no traffic:
  - next cycle DRAIN, then UNLOAD;
  - resync_irq_o asserts; ack; unload_done pulse;
  - core_rst_o=3'b111 for exactly 8 cycles;
  - reload_done pulse → RUN;
  - mismatch_cnt[1]=1, others 0; faulty_core_o=3'b010 during the sequence, 0 after.
- Mismatch while 2 data transactions are granted but not returned:
  - stays in DRAIN with bus_block_o=1;
  - leaves DRAIN the cycle after the second rvalid.
- error_cba_i=3'b011 → FAIL:
  - fail_o=1, bus_block_o=1, mismatch_cnt[0]=mismatch_cnt[1]=1;
  - stays in FAIL until rst_i.
- No unload_done for 1024 cycles in UNLOAD → FAIL with timeout_o=1; rst_i clears all.
- Core 0 mismatch 256 times with CntWidth=8 → counter saturates at 255; error_cba_i pulses while in RELOAD do not count.
- rst_i during RESET (cycle 3 of 8) → next edge state_o=0, core_rst_o=0, all counters 0.
